// File: rtl/fifo_64to16_unpacker.sv
// Read-side width down-converter: pulls wide words from a 1-cycle-latency FIFO
// and streams them out as narrow valid/ready beats, one lane per beat.
module fifo_64to16_unpacker #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16,
    parameter int MSB_FIRST = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    output logic                 fifo_rd_en,
    input  logic [IN_WIDTH-1:0]  fifo_rd_data,
    input  logic                 fifo_rd_empty,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 busy
);

    localparam int RATIO  = IN_WIDTH / OUT_WIDTH;
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    // Two-entry word buffer: word0_r is the head being unpacked, word1_r the tail.
    logic [IN_WIDTH-1:0]  word0_r;
    logic [IN_WIDTH-1:0]  word1_r;
    logic [1:0]           occ_r;
    logic [LANE_W-1:0]    lane_r;
    logic                 inflight_r;

    logic                 valid_s;
    logic                 fire_s;
    logic                 last_lane_s;
    logic                 pop_s;
    logic                 rd_en_s;
    logic                 wr_idx_s;
    logic [1:0]           occ_nxt_s;
    logic [LANE_W-1:0]    lane_nxt_s;
    logic [OUT_WIDTH-1:0] data_s;

    // Picks the beat for a lane; MSB_FIRST reverses the lane order within the word.
    function automatic logic [OUT_WIDTH-1:0] lane_select(
        input logic [IN_WIDTH-1:0] word,
        input logic [LANE_W-1:0]   lane
    );
        logic [LANE_W-1:0] idx;
        if (MSB_FIRST != 0) begin
            idx = LAST_LANE - lane;
        end else begin
            idx = lane;
        end
        return word[OUT_WIDTH*int'(idx) +: OUT_WIDTH];
    endfunction

    // Handshake, pop, read-issue and buffer bookkeeping decoded from registered state.
    always_comb begin
        valid_s     = (occ_r != 2'd0);
        fire_s      = valid_s & m_ready;
        last_lane_s = (lane_r == LAST_LANE);
        pop_s       = fire_s & last_lane_s;
        // Occupancy is taken pre-pop so a word in flight always has a free slot.
        rd_en_s     = !fifo_rd_empty & !flush & ((occ_r + {1'b0, inflight_r}) < 2'd2);
        occ_nxt_s   = occ_r + {1'b0, inflight_r} - {1'b0, pop_s};

        if (fire_s) begin
            if (last_lane_s) begin
                lane_nxt_s = {LANE_W{1'b0}};
            end else begin
                lane_nxt_s = lane_r + LANE_W'(1);
            end
        end else begin
            lane_nxt_s = lane_r;
        end

        // Arriving word lands in the first slot left free after this cycle's pop.
        case (occ_r)
            2'd0:    wr_idx_s = 1'b0;
            2'd1:    wr_idx_s = !pop_s;
            2'd2:    wr_idx_s = 1'b1;
            default: wr_idx_s = 1'b0;
        endcase

        if (valid_s) begin
            data_s = lane_select(word0_r, lane_r);
        end else begin
            data_s = {OUT_WIDTH{1'b0}};
        end
    end

    // Buffer, lane counter and in-flight tracking; reset beats flush beats normal flow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word0_r    <= {IN_WIDTH{1'b0}};
            word1_r    <= {IN_WIDTH{1'b0}};
            occ_r      <= 2'd0;
            lane_r     <= {LANE_W{1'b0}};
            inflight_r <= 1'b0;
        end else if (flush) begin
            occ_r      <= 2'd0;
            lane_r     <= {LANE_W{1'b0}};
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= rd_en_s;
            lane_r     <= lane_nxt_s;
            occ_r      <= occ_nxt_s;
            if (pop_s) begin
                word0_r <= word1_r;
            end
            if (inflight_r) begin
                if (wr_idx_s) begin
                    word1_r <= fifo_rd_data;
                end else begin
                    word0_r <= fifo_rd_data;
                end
            end
        end
    end

    assign fifo_rd_en = rd_en_s;
    assign m_valid    = valid_s;
    assign m_data     = data_s;
    assign busy       = valid_s | inflight_r;

endmodule
